// File: rtl/sd_otf_converter.sv
// sd_otf_converter
// Converts the radix-2 signed-digit product stream of the online multiplier
// (MSD first) into a two's-complement fraction using Q/QM on-the-fly
// conversion. The first DELTA enabled digits (online delay) are discarded,
// the next N digits are converted, and the final value is presented with a
// one-cycle valid pulse.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   en     - digit valid / operation active
//   z      - signed digit {plus, minus}: 10=+1, 01=-1, 00/11=0
//   result - N+1 bit two's-complement value x 2^N (held until next valid)
//   valid  - one-cycle pulse when result is updated
//   busy   - high from first accepted en until the operation ends
module sd_otf_converter #(
    parameter int unsigned N     = 8,
    parameter int unsigned DELTA = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [1:0]   z,
    output logic [N:0]   result,
    output logic         valid,
    output logic         busy
);

    localparam int unsigned MAX_CNT = (N > DELTA) ? N : DELTA;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKIP  = 2'd1,
        CONV  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N:0]       q_q;
    logic [N:0]       qm_q;
    logic [N:0]       q_d;
    logic [N:0]       qm_d;
    logic [N:0]       result_q;
    logic             valid_q;
    logic             busy_q;

    logic dig_pos;
    logic dig_neg;

    // Digit decode: 00 and 11 both mean zero.
    assign dig_pos = z[1] & ~z[0];
    assign dig_neg = z[0] & ~z[1];

    // On-the-fly recurrence; keeps QM = Q - 1 so no carry propagation is needed.
    always_comb begin
        q_d  = q_q;
        qm_d = qm_q;
        if (dig_pos) begin
            q_d  = {q_q[N-1:0], 1'b1};
            qm_d = {q_q[N-1:0], 1'b0};
        end else if (dig_neg) begin
            q_d  = {qm_q[N-1:0], 1'b1};
            qm_d = {qm_q[N-1:0], 1'b0};
        end else begin
            q_d  = {q_q[N-1:0], 1'b0};
            qm_d = {qm_q[N-1:0], 1'b1};
        end
    end

    // Control FSM with registered outputs; en low in SKIP/CONV stalls everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            q_q      <= '0;
            qm_q     <= '1;
            result_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en) begin
                        busy_q <= 1'b1;
                        // This edge is skip digit 1.
                        if (DELTA <= 1) begin
                            state_q <= CONV;
                            cnt_q   <= '0;
                            q_q     <= '0;
                            qm_q    <= '1;
                        end else begin
                            state_q <= SKIP;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                end
                SKIP: begin
                    if (en) begin
                        if (cnt_q == CNT_W'(DELTA - 1)) begin
                            state_q <= CONV;
                            cnt_q   <= '0;
                            q_q     <= '0;
                            qm_q    <= '1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                CONV: begin
                    if (en) begin
                        q_q  <= q_d;
                        qm_q <= qm_d;
                        if (cnt_q == CNT_W'(N - 1)) begin
                            result_q <= q_d;
                            valid_q  <= 1'b1;
                            cnt_q    <= '0;
                            state_q  <= FLUSH;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    // en held high past the last digit never restarts an operation.
                    if (!en) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result = result_q;
    assign valid  = valid_q;
    assign busy   = busy_q;

endmodule

// File: doc/sd_otf_converter.md
# sd_otf_converter

Downstream stage of the 1-D online multiplier. Consumes the radix-2 signed-digit product stream `z`, most significant digit first, and converts it on the fly into a two's-complement fraction. It discards the multiplier's online-delay digits, accumulates N result digits with the Q/QM on-the-fly conversion recurrence, and presents the final value with a one-cycle valid pulse. No carry-propagate adder sits on the digit path.

## Interface
- `N`, 8: number of result digits converted per operation (N ≥ 2).
- `DELTA`, 3: online delay, i.e. the number of leading enabled cycles whose `z` digits are discarded.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `en`  input  1  digit-valid / operation-active, driven by the same control that drives the multiplier's `en`.
- `z`  input  2  signed digit `{plus, minus}`. `10` = +1, `01` = −1, `00` and `11` = 0.
- `result`  output  N+1  two's-complement value × 2^N: sign bit plus N fraction bits, range −(2^N−1)..+(2^N−1).
- `valid`  output  1  one-cycle pulse; `result` is new and stable.
- `busy`  output  1  high from the first accepted `en` until the operation ends (FLUSH exited).

## Operation
- Reset values: `result` = 0, `valid` = 0, `busy` = 0, Q = 0, QM = all ones (−1), counter = 0, state = IDLE.
- States and transitions:
  - IDLE → SKIP on `en` = 1. That edge counts as skip digit 1. If DELTA = 1, go straight to CONV.
  - SKIP: count enabled edges. Move to CONV after DELTA skipped digits. `z` is ignored.
  - CONV: each enabled edge consumes one digit. After the Nth digit, register `result` and assert `valid`, then go to FLUSH.
  - FLUSH: ignore `z`. Return to IDLE on the first edge with `en` = 0. If `en` is already 0 at the Nth-digit edge, go directly to IDLE.
- `en` = 0 while in SKIP or CONV is a stall: counter, Q and QM hold, no digit is consumed, and the state is unchanged.
- On-the-fly recurrence (N+1-bit registers, shift left by one per digit). On entry to CONV, Q = 0 and QM = all ones.
  - d = +1: Q ← {Q, 1}, QM ← {Q, 0}
  - d = 0: Q ← {Q, 0}, QM ← {QM, 1}
  - d = −1: Q ← {QM, 1}, QM ← {QM, 0}
- Invariant: QM = Q − 1 at every step. Bits shifted out of the top are dropped.
- Output value: `result` = Q after N digits = Σ d_i·2^(N−i). Overflow is not possible.
- `result` holds its value until the next operation's `valid`. It is not cleared on entry to IDLE.
- `rst` mid-operation returns every register to its reset value immediately (asynchronous). The interrupted operation produces no `valid`.

## Timing
- Let E0 be the first rising edge with `en` = 1 in IDLE.
  - Skip digits are sampled at E0 .. E0+DELTA−1.
  - Result digits are sampled at E0+DELTA .. E0+DELTA+N−1 when there are no stalls.
- `valid` and the new `result` appear after edge E0+DELTA+N−1 and `valid` stays high for exactly one cycle. Each stalled cycle adds one cycle to this.
- Total latency with no stalls: DELTA+N edges from E0 to `valid`.
- `busy` rises after E0 and falls after the edge that leaves FLUSH, or after the Nth-digit edge if `en` is already 0.
- Back-to-back operations need at least one cycle with `en` = 0 between them. `en` held high past N digits never starts a new operation.

## Test plan
- N=8, DELTA=3, three zero skip digits, then digits +1,0,0,0,0,0,0,0 → `result` = 9'h080, one-cycle `valid` at edge E0+10, `busy` high throughout.
- Digits −1,+1,0,0,0,0,0,0 → `result` = 9'h1C0 (−64). Repeat with zeros encoded as `11` → same result.
- Digits all −1 → `result` = 9'h101 (−255). Digits alternating +1,−1 (starting +1) → `result` = 9'h055 (85).
- Digits +1,−1,+1,−1,… with `en` dropped for 2 cycles after digit 4 and non-zero `z` during the stall → `result` = 9'h055, `valid` 2 cycles later than unstalled, no extra digits consumed.
- `rst` asserted between edges after digit 4, then released → all outputs and registers immediately at reset values, no `valid`. A following full operation with digits +1,0,… → 9'h080.
- `en` held high for 4 cycles past digit 8 with random `z` → single `valid`, `result` unchanged, FLUSH until `en` = 0. A new `en` then starts a fresh skip phase.
